// File: rtl/myproject_arith_pkg.sv
// Shared arithmetic constants and helpers for the multiplier, adder and accumulator cores.
// Width-dependent min/max values are returned in 64-bit containers; callers slice the low N bits.
package myproject_arith_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] smax(input int unsigned n);
    return (MAX_WIDTH'(1) << (n - 1)) - MAX_WIDTH'(1);
  endfunction

  // Low n bits of the inverted max are 100..0, the most negative n-bit value.
  function automatic logic [MAX_WIDTH-1:0] smin(input int unsigned n);
    return ~smax(n);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] umax(input int unsigned n);
    if (n >= MAX_WIDTH) return '1;
    return (MAX_WIDTH'(1) << n) - MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/myproject_pipe_reg_hs.sv
// One valid/ready register stage. An empty stage always accepts, so bubbles collapse
// even when the downstream side is stalled.
module myproject_pipe_reg_hs #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             adv;

  always_comb begin
    adv     = ce & (~valid_q | out_ready);
    valid_d = valid_q;
    data_d  = data_q;
    if (adv) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/myproject_mul_pipe_hs.sv
// Pipelined multiplier with valid/ready handshake, per-operand signedness and optional
// saturation. Stages 0..NUM_STAGE-2 carry the full product; the last carries {ovf, dout}.
module myproject_mul_pipe_hs
  import myproject_arith_pkg::*;
#(
  parameter int          ID          = 1,
  parameter int unsigned NUM_STAGE   = 2,
  parameter int unsigned din0_WIDTH  = 15,
  parameter int unsigned din1_WIDTH  = 14,
  parameter int unsigned dout_WIDTH  = 28,
  parameter int unsigned DIN0_SIGNED = 0,
  parameter int unsigned DIN1_SIGNED = 0,
  parameter int unsigned SATURATE    = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int unsigned P          = prod_width(din0_WIDTH, din1_WIDTH);
  localparam bit          RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  // Extending both operands to P bits makes the low P bits of the product exact
  // for every signedness combination.
  logic         sx0, sx1;
  logic [P-1:0] a_w, b_w, prod;

  assign sx0  = (DIN0_SIGNED != 0) & din0[din0_WIDTH-1];
  assign sx1  = (DIN1_SIGNED != 0) & din1[din1_WIDTH-1];
  assign a_w  = {{din1_WIDTH{sx0}}, din0};
  assign b_w  = {{din0_WIDTH{sx1}}, din1};
  assign prod = a_w * b_w;

  logic         stg_valid [NUM_STAGE+1];
  logic         stg_ready [NUM_STAGE+1];
  logic [P-1:0] stg_prod  [NUM_STAGE];

  assign stg_valid[0]         = in_valid;
  assign stg_prod[0]          = prod;
  assign stg_ready[NUM_STAGE] = out_ready;
  assign out_valid            = stg_valid[NUM_STAGE];
  assign in_ready             = stg_ready[0] & ~ap_rst;

  for (genvar k = 0; k < int'(NUM_STAGE) - 1; k++) begin : g_stage
    myproject_pipe_reg_hs #(
      .WIDTH(P)
    ) u_stage (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .ce       (ce),
      .in_valid (stg_valid[k]),
      .in_ready (stg_ready[k]),
      .in_data  (stg_prod[k]),
      .out_valid(stg_valid[k+1]),
      .out_ready(stg_ready[k+1]),
      .out_data (stg_prod[k+1])
    );
  end

  logic [P-1:0]          nar_src;
  logic [dout_WIDTH-1:0] nar_dout;
  logic                  nar_ovf;

  assign nar_src = stg_prod[NUM_STAGE-1];

  if (dout_WIDTH >= P) begin : g_widen
    always_comb begin
      nar_ovf = 1'b0;
      if (RES_SIGNED) nar_dout = dout_WIDTH'($signed(nar_src));
      else            nar_dout = dout_WIDTH'(nar_src);
    end
  end else begin : g_narrow
    localparam logic [MAX_WIDTH-1:0] SMAX_V = smax(dout_WIDTH);
    localparam logic [MAX_WIDTH-1:0] SMIN_V = smin(dout_WIDTH);
    localparam logic [MAX_WIDTH-1:0] UMAX_V = umax(dout_WIDTH);

    // Upper slice includes the kept MSB so a signed result fits only if all bits agree.
    logic [P-dout_WIDTH:0] upper;
    logic                  fits;

    assign upper = nar_src[P-1:dout_WIDTH-1];
    assign fits  = RES_SIGNED ? ((upper == '0) || (upper == '1))
                              : (upper[P-dout_WIDTH:1] == '0);

    always_comb begin
      nar_dout = nar_src[dout_WIDTH-1:0];
      nar_ovf  = ~fits;
      if ((SATURATE != 0) && !fits) begin
        if (!RES_SIGNED)       nar_dout = UMAX_V[dout_WIDTH-1:0];
        else if (nar_src[P-1]) nar_dout = SMIN_V[dout_WIDTH-1:0];
        else                   nar_dout = SMAX_V[dout_WIDTH-1:0];
      end
    end
  end

  logic [dout_WIDTH:0] last_data;

  myproject_pipe_reg_hs #(
    .WIDTH(dout_WIDTH + 1)
  ) u_last (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ce       (ce),
    .in_valid (stg_valid[NUM_STAGE-1]),
    .in_ready (stg_ready[NUM_STAGE-1]),
    .in_data  ({nar_ovf, nar_dout}),
    .out_valid(stg_valid[NUM_STAGE]),
    .out_ready(stg_ready[NUM_STAGE]),
    .out_data (last_data)
  );

  assign ovf  = last_data[dout_WIDTH];
  assign dout = last_data[dout_WIDTH-1:0];

endmodule

// File: tb/tb_myproject_mul_pipe_hs.sv
// Directed bench for myproject_mul_pipe_hs: default unsigned instance plus three
// signed 8x8 instances (widening, saturating, wrapping) sharing one stimulus bus.
module tb_myproject_mul_pipe_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;

  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [14:0] din0;
  logic [13:0] din1;
  logic [27:0] dout;

  logic        s_valid;
  logic [7:0]  s_din0, s_din1;
  logic        w_ir, w_ov, w_ovf;
  logic [15:0] w_dout;
  logic        t_ir, t_ov, t_ovf;
  logic [7:0]  t_dout;
  logic        r_ir, r_ov, r_ovf;
  logic [7:0]  r_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  myproject_mul_pipe_hs u_def (
    .ap_clk(clk), .ap_rst(rst), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .ovf(ovf)
  );

  myproject_mul_pipe_hs #(
    .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16),
    .DIN0_SIGNED(1), .DIN1_SIGNED(1), .SATURATE(0)
  ) u_wide (
    .ap_clk(clk), .ap_rst(rst), .ce(ce),
    .in_valid(s_valid), .in_ready(w_ir), .din0(s_din0), .din1(s_din1),
    .out_valid(w_ov), .out_ready(1'b1), .dout(w_dout), .ovf(w_ovf)
  );

  myproject_mul_pipe_hs #(
    .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
    .DIN0_SIGNED(1), .DIN1_SIGNED(1), .SATURATE(1)
  ) u_sat (
    .ap_clk(clk), .ap_rst(rst), .ce(ce),
    .in_valid(s_valid), .in_ready(t_ir), .din0(s_din0), .din1(s_din1),
    .out_valid(t_ov), .out_ready(1'b1), .dout(t_dout), .ovf(t_ovf)
  );

  myproject_mul_pipe_hs #(
    .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
    .DIN0_SIGNED(1), .DIN1_SIGNED(1), .SATURATE(0)
  ) u_wrap (
    .ap_clk(clk), .ap_rst(rst), .ce(ce),
    .in_valid(s_valid), .in_ready(r_ir), .din0(s_din0), .din1(s_din1),
    .out_valid(r_ov), .out_ready(1'b1), .dout(r_dout), .ovf(r_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_s(input logic [7:0] a, input logic [7:0] b);
    tick();
    s_valid = 1'b1; s_din0 = a; s_din1 = b;
    tick();
    s_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, dlv, occ;
    bit prev_stall, in_fire, out_fire;
    logic [27:0] prev_dout;
    logic        prev_ovf;

    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    din0 = '0; din1 = '0; s_valid = 1'b0; s_din0 = '0; s_din1 = '0;

    // Reset state
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_sat_valid", 64'(t_ov), 64'd0);

    // 1: default unsigned 15x14 -> 28, max operands wrap past 28 bits
    tick();
    rst = 1'b0; in_valid = 1'b1; din0 = 15'd32767; din1 = 14'd16383;
    #1 check("t1_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("t1_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    check("t1_lat2_valid", 64'(out_valid), 64'd1);
    check("t1_dout", 64'(dout), 64'h0FFF4001);
    check("t1_ovf", 64'(ovf), 64'd1);
    in_valid = 1'b1; din0 = 15'd1000; din1 = 14'd1000;
    tick();
    in_valid = 1'b0;
    tick();
    check("t1b_dout", 64'(dout), 64'd1000000);
    check("t1b_ovf", 64'(ovf), 64'd0);
    tick();
    check("t1_drain", 64'(out_valid), 64'd0);

    // 2: signed 8x8 -> 16
    send_s(8'h80, 8'h80);
    check("t2_valid", 64'(w_ov), 64'd1);
    check("t2_neg_neg", 64'(w_dout), 64'd16384);
    check("t2_ovf", 64'(w_ovf), 64'd0);
    check("t2_sat_clamp", 64'(t_dout), 64'h7F);
    send_s(8'h80, 8'd127);
    check("t2_neg_pos", 64'(w_dout), 64'hC080);
    check("t2_wrap_lo", 64'(r_dout), 64'h80);
    check("t2_wrap_ovf", 64'(r_ovf), 64'd1);

    // 3: saturate vs wrap, signed 8x8 -> 8
    send_s(8'd100, 8'd3);
    check("t3_sat_pos", 64'(t_dout), 64'h7F);
    check("t3_sat_pos_ovf", 64'(t_ovf), 64'd1);
    check("t3_wrap_pos", 64'(r_dout), 64'd44);
    check("t3_wrap_pos_ovf", 64'(r_ovf), 64'd1);
    check("t3_wide_300", 64'(w_dout), 64'h012C);
    send_s(8'h9C, 8'd3);
    check("t3_sat_neg", 64'(t_dout), 64'h80);
    check("t3_sat_neg_ovf", 64'(t_ovf), 64'd1);
    check("t3_wrap_neg", 64'(r_dout), 64'hD4);
    send_s(8'd5, 8'hFA);
    check("t3_sat_fit", 64'(t_dout), 64'hE2);
    check("t3_sat_fit_ovf", 64'(t_ovf), 64'd0);
    check("t3_wrap_fit_ovf", 64'(r_ovf), 64'd0);

    // 4: backpressure stream 1..20, times 3
    sent = 0; dlv = 0; prev_stall = 1'b0; prev_dout = '0; prev_ovf = 1'b0;
    for (int cyc = 0; cyc < 400 && dlv < 20; cyc++) begin
      tick();
      in_valid  = (sent < 20);
      din0      = 15'(sent + 1);
      din1      = 14'd3;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      occ = sent - dlv;
      if (prev_stall) begin
        check("t4_stall_valid", 64'(out_valid), 64'd1);
        check("t4_stall_dout", 64'(dout), 64'(prev_dout));
        check("t4_stall_ovf", 64'(ovf), 64'(prev_ovf));
      end
      check("t4_in_ready", 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        check("t4_dout", 64'(dout), 64'(3 * (dlv + 1)));
        dlv++;
      end
      if (in_fire) sent++;
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
      prev_ovf   = ovf;
    end
    check("t4_delivered", 64'(dlv), 64'd20);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("t4_drained", 64'(out_valid), 64'd0);

    // 5: ce=0 freeze with data in flight
    in_valid = 1'b1; din0 = 15'd11; din1 = 14'd2;
    tick();
    din0 = 15'd12;
    tick();
    ce = 1'b0; din0 = 15'd13;
    #1;
    check("t5_freeze_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_freeze_valid", 64'(out_valid), 64'd1);
      check("t5_freeze_dout", 64'(dout), 64'd22);
      check("t5_freeze_in_ready", 64'(in_ready), 64'd0);
    end
    ce = 1'b1;
    #1 check("t5_resume_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("t5_resume_dout1", 64'(dout), 64'd24);
    tick();
    check("t5_resume_dout2", 64'(dout), 64'd26);
    check("t5_resume_valid", 64'(out_valid), 64'd1);
    tick();
    check("t5_drained", 64'(out_valid), 64'd0);

    // 6: reset with two results in flight
    out_ready = 1'b0; in_valid = 1'b1; din0 = 15'd3; din1 = 14'd3;
    tick();
    din0 = 15'd4; din1 = 14'd4;
    tick();
    check("t6_full_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0; rst = 1'b1;
    #1 check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_dout", 64'(dout), 64'd0);
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; din0 = 15'd7; din1 = 14'd9;
    #1 check("t6_post_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("t6_post_lat1", 64'(out_valid), 64'd0);
    tick();
    check("t6_post_valid", 64'(out_valid), 64'd1);
    check("t6_post_dout", 64'(dout), 64'd63);
    check("t6_post_ovf", 64'(ovf), 64'd0);
    tick();
    check("t6_no_dup", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
